// File: rtl/uart_rx_sipo_if.sv
// rtl/uart_rx_sipo_if.sv - serial line and parallel byte bundle for the 8N1 receiver
//
// Signals:
//   rxd         serial line into the receiver, idles high
//   data_out    last byte received with a good stop bit
//   data_valid  one-cycle strobe when data_out updates
//   frame_err   one-cycle strobe when a stop bit is sampled low
//   busy        receiver is inside a frame
// Modports:
//   master  the receiver (consumes rxd, drives the byte side)
//   slave   the pin driver / byte consumer
interface uart_rx_sipo_if;
    logic       rxd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rxd,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rxd,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_sipo.sv
// rtl/uart_rx_sipo.sv - 8N1 UART receive deserializer with midpoint sampling
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-low reset
//   bus   uart_rx_sipo_if.master: rxd in; data_out, data_valid, frame_err, busy out
// Parameter:
//   CLKS_PER_BIT  clocks per bit period, even and >= 4
module uart_rx_sipo #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_sipo_if.master bus
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic          s1, rx_s;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          armed, armed_nx;
    logic [7:0]    data_q, data_nx;
    logic          valid_q, valid_nx;
    logic          err_q, err_nx;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never looks like a falling start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1   <= bus.rxd;
            rx_s <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            armed   <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            armed   <= armed_nx;
            data_q  <= data_nx;
            valid_q <= valid_nx;
            err_q   <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        armed_nx   = armed;
        data_nx    = data_q;
        valid_nx   = 1'b0;
        err_nx     = 1'b0;

        case (state)
            IDLE: begin
                // Arming needs a high line first, so a held-low break
                // after a frame error cannot start a new frame.
                if (rx_s) begin
                    armed_nx = 1'b1;
                end else if (armed) begin
                    state_nx = START;
                    cnt_nx   = '0;
                    armed_nx = 1'b0;
                end
            end

            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nx = '0;
                    if (!rx_s) begin
                        state_nx   = DATA;
                        bit_idx_nx = 3'd0;
                    end else begin
                        // Line went back high before mid-start: glitch.
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    if (rx_s) begin
                        data_nx  = shift;
                        valid_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: doc/uart_rx_sipo.md
# uart_rx_sipo

UART receiver front end: serial-in, parallel-out deserializer for 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It is the receive-side counterpart of the transmitter's PISO shifter. It synchronizes the asynchronous `rxd` line, detects and validates start bits, samples each bit at its midpoint, and presents each received byte with a single-cycle valid strobe. It sits between the board RX pin and the receive FIFO or consumer logic.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Must be an even integer ≥ 4.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `rxd`  input  1  asynchronous serial line; idles high.
- `data_out`  output  8  last byte received with a good stop bit.
- `data_valid`  output  1  one-cycle pulse when `data_out` updates.
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Synchronizer: two flops, `rxd` → `s1` → `rx_s`. Reset value of both is 1. All decisions use `rx_s` only.
- Reset (`rst`=0 at a clock edge), which overrides everything, including a frame in progress:
  - state = IDLE
  - bit counter and cycle counter = 0
  - `data_out` = 8'h00; `data_valid`, `frame_err`, `busy` = 0
  - armed flag = 0
- Armed flag: set when `rx_s`=1 is seen in IDLE. Cleared on entry to START. A start is accepted only while armed, so a line held low (break) does not retrigger.
- States:
  - IDLE: if armed and `rx_s`=0, go to START and clear the cycle counter.
  - START: count cycles. At count CLKS_PER_BIT/2−1, sample `rx_s`:
    - 0 → go to DATA, clear the counter and the bit index.
    - 1 → treat as a glitch and return to IDLE. No output activity.
  - DATA: count to CLKS_PER_BIT−1, then sample `rx_s` into `shift[bit_idx]` (LSB first) and clear the counter. After bit 7 is sampled, go to STOP.
  - STOP: count to CLKS_PER_BIT−1, then sample `rx_s`:
    - 1 → `data_out` ← shift, pulse `data_valid`.
    - 0 → pulse `frame_err`; `data_out` is unchanged.
    - Either way, go to IDLE.
- The cycle counter width is clog2(CLKS_PER_BIT). It never wraps in use, because it is cleared at every sample point.
- `data_valid` and `frame_err` are never high in the same cycle.

## Timing
- Let T0 be the first edge at which IDLE sees `rx_s`=0 while armed. START is occupied from T0+1.
- Sample points, with N = CLKS_PER_BIT:
  - start check at T0+N/2
  - data bit k (k = 0..7) at T0+N/2+(k+1)·N
  - stop bit at T0+N/2+9N
- `data_valid` / `frame_err` are registered: high for exactly the one cycle after the stop sample. `data_out` changes in that same cycle and holds until the next good frame.
- `busy` rises in the cycle after T0 and falls together with the valid/error pulse.
- `rxd`-to-`rx_s` latency is 2 cycles.
- Back-to-back frames: IDLE is re-entered about N/2 cycles before the stop bit ends, and the next start edge is accepted normally (armed is set because the stop bit is high).
- After a frame error, the receiver stays in IDLE until `rx_s` returns high.

## Test plan
- Nominal byte: N=16, send 8'h5D as an 8N1 frame at 16 clocks per bit → one `data_valid` pulse with `data_out`=8'h5D, `frame_err`=0, `busy` high for the whole frame only.
- Back-to-back: send 8'h00, 8'hFF, 8'hA5 with no idle gap → three `data_valid` pulses, spaced exactly 160 cycles apart, with values 00, FF, A5 in order.
- Glitch rejection: drive `rxd` low for 3 cycles, then high → `busy` pulses briefly, no `data_valid`, no `frame_err`, `data_out` unchanged.
- Framing error and break: send 8'h3C with the stop bit low, then hold `rxd` low for 40 bit times → exactly one `frame_err` pulse, no `data_valid`, no further activity until `rxd` rises. A following 8'h3C frame is then received correctly.
- Reset mid-frame: assert `rst`=0 for one cycle during data bit 4 of a frame → next cycle has state IDLE, `busy`=0, `data_out`=00, no pulse for the aborted frame. The next full frame 8'h81 is received correctly.
- Parameter sweep: repeat the nominal test with N=4 and N=868 → correct byte and correct sample-point timing.
